// File: rtl/dpi_stream_sequencer.sv
// Flow-tag to stream-id sequencer that paces the broadcast control bus of the DPI matcher bank.
// Define DPI_SEQ_ERRCNT_EN to build the saturating protocol-error counter on port err_cnt.
module dpi_stream_sequencer #(
  parameter int unsigned NUM_REGEX = 16,
  parameter int unsigned TAG_W     = 16,
  parameter int unsigned LOAD_GAP  = 2,
  parameter int unsigned DRAIN_GAP = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sop,
  input  logic                 in_eop,
  input  logic [7:0]           in_data,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic [NUM_REGEX-1:0] dflt_mask,
  input  logic                 cfg_we,
  input  logic [5:0]           cfg_stream,
  input  logic [NUM_REGEX-1:0] cfg_mask,
  output logic                 load_state,
  output logic [7:0]           char_in,
  output logic                 char_in_vld,
  output logic                 eop,
  output logic [5:0]           stream_id,
  output logic                 new_stream_id,
  output logic [NUM_REGEX-1:0] enable,
  output logic                 busy
`ifdef DPI_SEQ_ERRCNT_EN
  ,
  output logic [15:0]          err_cnt
`endif
);

  typedef enum logic [2:0] {StIdle, StLookup, StLoad, StGap, StStream, StDrain, StEop} state_e;

  localparam logic [7:0] GapInit   = 8'(LOAD_GAP > 2 ? LOAD_GAP - 3 : 0);
  localparam logic [7:0] DrainLast = 8'(DRAIN_GAP - 1);

  state_e                 state_q, state_d;
  logic [TAG_W-1:0]       tag_q;
  logic                   got_q, got_d;
  logic [7:0]             gap_q, gap_d;
  logic [7:0]             since_q;
  logic                   accept;

  logic [63:0]            valid_q;
  logic [TAG_W-1:0]       tag_tbl_q [64];
  logic [NUM_REGEX-1:0]   mask_q [64];
  logic [5:0]             victim_q;

  logic                   hit, free;
  logic [5:0]             hit_idx, free_idx, alloc_idx;
  logic                   alloc;

  logic [5:0]             sid_q;
  logic                   new_q;
  logic [NUM_REGEX-1:0]   en_q;
  logic [7:0]             char_q;
  logic                   vld_q;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    got_d    = got_q;
    gap_d    = gap_q;
    unique case (state_q)
      StIdle: begin
        // Non-SOP beats in IDLE are swallowed; a SOP beat is held for STREAM.
        if (in_valid) begin
          if (in_sop) state_d = StLookup;
          else        in_ready = 1'b1;
        end
      end
      StLookup: state_d = StLoad;
      StLoad: begin
        got_d   = 1'b0;
        gap_d   = GapInit;
        state_d = (LOAD_GAP > 2) ? StGap : StStream;
      end
      StGap: begin
        if (gap_q == 8'd0) state_d = StStream;
        else               gap_d   = gap_q - 8'd1;
      end
      StStream: begin
        // Only the packet's own first byte may carry SOP; a later SOP closes the packet.
        if (in_valid && in_sop && got_q) begin
          state_d = StDrain;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            accept = 1'b1;
            got_d  = 1'b1;
            if (in_eop) state_d = StDrain;
          end
        end
      end
      StDrain: if (since_q >= DrainLast) state_d = StEop;
      StEop:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Lowest index wins for both hit and free-slot search.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = 63; i >= 0; i--) begin
      if (valid_q[i] && tag_tbl_q[i] == tag_q) begin
        hit     = 1'b1;
        hit_idx = 6'(i);
      end
      if (!valid_q[i]) begin
        free     = 1'b1;
        free_idx = 6'(i);
      end
    end
  end

  assign alloc_idx = free ? free_idx : victim_q;
  assign alloc     = (state_q == StLookup) && !hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tag_q   <= '0;
      got_q   <= 1'b0;
      gap_q   <= '0;
      since_q <= 8'hFF;
      char_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      got_q   <= got_d;
      gap_q   <= gap_d;
      vld_q   <= accept;
      if (accept) char_q <= in_data;
      if (state_q == StIdle && in_valid && in_sop) tag_q <= in_tag;
      // Cycles since the last char_in_vld; paces eop after normal and aborted packets alike.
      if (accept)                since_q <= '0;
      else if (since_q != 8'hFF) since_q <= since_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= '0;
      victim_q <= '0;
      for (int i = 0; i < 64; i++) begin
        tag_tbl_q[i] <= '0;
        mask_q[i]    <= '0;
      end
    end else begin
      if (alloc) begin
        valid_q[alloc_idx]   <= 1'b1;
        tag_tbl_q[alloc_idx] <= tag_q;
        mask_q[alloc_idx]    <= dflt_mask;
        if (!free) victim_q <= victim_q + 6'd1;
      end
      // Issued after the allocation write so a same-entry cfg write takes priority.
      if (cfg_we) mask_q[cfg_stream] <= cfg_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sid_q <= '0;
      new_q <= 1'b0;
      en_q  <= '0;
    end else if (state_q == StLookup) begin
      sid_q <= hit ? hit_idx : alloc_idx;
      new_q <= !hit;
      if (hit)                                  en_q <= mask_q[hit_idx];
      else if (cfg_we && cfg_stream == alloc_idx) en_q <= cfg_mask;
      else                                      en_q <= dflt_mask;
    end
  end

  assign load_state    = (state_q == StLoad);
  assign eop           = (state_q == StEop);
  assign busy          = (state_q != StIdle);
  assign char_in       = char_q;
  assign char_in_vld   = vld_q;
  assign stream_id     = sid_q;
  assign new_stream_id = new_q;
  assign enable        = en_q;

`ifdef DPI_SEQ_ERRCNT_EN
  logic        err_evt;
  logic [15:0] err_q;

  assign err_evt = (state_q == StIdle && in_valid && !in_sop) ||
                   (state_q == StStream && in_valid && in_sop && got_q);

  always_ff @(posedge clk) begin
    if (!rst_n)                             err_q <= '0;
    else if (err_evt && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
  end

  assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Bench for dpi_stream_sequencer: timeline/table model checked every cycle plus directed literals.
module tb_dpi_stream_sequencer;

  localparam int unsigned NR = 16;
  localparam int unsigned TW = 16;
  localparam int unsigned LG = 2;
  localparam int unsigned DG = 4;
  localparam logic [15:0] Dflt = 16'h00FF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, in_sop, in_eop;
  logic [7:0]    in_data;
  logic [TW-1:0] in_tag;
  logic [NR-1:0] dflt_mask;
  logic          cfg_we;
  logic [5:0]    cfg_stream;
  logic [NR-1:0] cfg_mask;
  logic          load_state, char_in_vld, eop, new_stream_id, busy;
  logic [7:0]    char_in;
  logic [5:0]    stream_id;
  logic [NR-1:0] enable;
`ifdef DPI_SEQ_ERRCNT_EN
  logic [15:0]   err_cnt;
`endif

  dpi_stream_sequencer #(
    .NUM_REGEX (NR),
    .TAG_W     (TW),
    .LOAD_GAP  (LG),
    .DRAIN_GAP (DG)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sop        (in_sop),
    .in_eop        (in_eop),
    .in_data       (in_data),
    .in_tag        (in_tag),
    .dflt_mask     (dflt_mask),
    .cfg_we        (cfg_we),
    .cfg_stream    (cfg_stream),
    .cfg_mask      (cfg_mask),
    .load_state    (load_state),
    .char_in       (char_in),
    .char_in_vld   (char_in_vld),
    .eop           (eop),
    .stream_id     (stream_id),
    .new_stream_id (new_stream_id),
    .enable        (enable),
    .busy          (busy)
`ifdef DPI_SEQ_ERRCNT_EN
    ,
    .err_cnt       (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: flow table as plain arrays, packet timing as absolute cycle stamps.
  bit          m_primed, m_pkt, m_closed, m_acc_prev, m_after_rst;
  int          m_t_lookup, m_t_load, m_t_ready, m_eop_at, m_last_vld, m_nbytes, m_err;
  logic [7:0]  m_data_prev;
  logic [15:0] m_tag_pend;
  logic [15:0] m_tag [64];
  bit          m_valid [64];
  logic [15:0] m_mask [64];
  int          m_victim;
  logic [5:0]  m_sid;
  bit          m_new;
  logic [15:0] m_en;
  bit          exp_ready;

  task automatic model_reset();
    m_pkt = 0; m_closed = 0; m_acc_prev = 0; m_after_rst = 1; m_err = 0; m_victim = 0;
    m_eop_at = -1;
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_mask[i] = '0;
    end
  endtask

  task automatic model_lookup();
    int idx;
    idx = -1;
    for (int i = 0; i < 64; i++)
      if (idx < 0 && m_valid[i] && m_tag[i] == m_tag_pend) idx = i;
    if (idx >= 0) begin
      m_sid = 6'(idx); m_new = 0; m_en = m_mask[idx];
    end else begin
      for (int i = 0; i < 64; i++)
        if (idx < 0 && !m_valid[i]) idx = i;
      if (idx < 0) begin
        idx = m_victim;
        m_victim = (m_victim + 1) % 64;
      end
      m_valid[idx] = 1; m_tag[idx] = m_tag_pend; m_mask[idx] = dflt_mask;
      m_sid = 6'(idx); m_new = 1;
      m_en = (cfg_we && cfg_stream == 6'(idx)) ? cfg_mask : dflt_mask;
    end
    m_after_rst = 0;
  endtask

  always @(negedge clk) begin
    if (m_pkt) exp_ready = cyc >= m_t_ready && !m_closed && !(in_valid && in_sop && m_nbytes > 0);
    else       exp_ready = in_valid && !in_sop;
    if (m_primed) begin
      chk("in_ready", in_ready, exp_ready);
      chk("load_state", load_state, m_pkt && cyc == m_t_load);
      chk("eop", eop, m_pkt && cyc == m_eop_at);
      chk("busy", busy, m_pkt);
      chk("char_in_vld", char_in_vld, m_acc_prev);
      if (m_acc_prev) chk("char_in", char_in, m_data_prev);
      if (m_pkt && cyc >= m_t_load) begin
        chk("stream_id", stream_id, m_sid);
        chk("new_stream_id", new_stream_id, m_new);
        chk("enable", enable, m_en);
      end else if (m_after_rst) begin
        chk("rst_stream_id", stream_id, 0);
        chk("rst_new_stream_id", new_stream_id, 0);
        chk("rst_enable", enable, 0);
      end
`ifdef DPI_SEQ_ERRCNT_EN
      chk("err_cnt", err_cnt, m_err);
`endif
    end
    if (!rst_n) begin
      model_reset();
      m_primed = 1;
    end else if (m_primed) begin
      m_acc_prev = 0;
      if (!m_pkt) begin
        if (in_valid && in_sop) begin
          m_pkt = 1; m_closed = 0; m_nbytes = 0; m_eop_at = -1; m_tag_pend = in_tag;
          m_t_lookup = cyc + 1; m_t_load = cyc + 2; m_t_ready = cyc + 1 + LG;
        end else if (in_valid) begin
          m_err++;
        end
      end else begin
        if (cyc == m_t_lookup) model_lookup();
        if (exp_ready && in_valid) begin
          m_acc_prev = 1; m_data_prev = in_data; m_nbytes++; m_last_vld = cyc + 1;
          if (in_eop) begin
            m_closed = 1; m_eop_at = cyc + 1 + DG;
          end
        end else if (cyc >= m_t_ready && !m_closed && in_valid && in_sop) begin
          m_closed = 1; m_err++;
          m_eop_at = (m_last_vld + DG > cyc + 2) ? m_last_vld + DG : cyc + 2;
        end
        if (cyc == m_eop_at) m_pkt = 0;
      end
      if (cfg_we) m_mask[cfg_stream] = cfg_mask;
    end
  end

  // Per-packet observations for the directed literal checks.
  int          rec_load, rec_first, rec_last, rec_nvld, rec_eop, n_eop;
  logic [5:0]  rec_sid;
  logic        rec_new;
  logic [15:0] rec_en;

  always @(negedge clk) begin
    if (load_state) begin
      rec_load = cyc; rec_sid = stream_id; rec_new = new_stream_id; rec_en = enable;
      rec_first = -1; rec_nvld = 0;
    end
    if (char_in_vld) begin
      if (rec_first < 0) rec_first = cyc;
      rec_last = cyc; rec_nvld++;
    end
    if (eop) begin
      rec_eop = cyc; n_eop++;
    end
  end

  int sop_cyc;

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic drive_beat(input logic sop, input logic last, input logic [7:0] d,
                            input logic [15:0] tag);
    int  n;
    bit  done;
    n = 0; done = 0;
    in_valid = 1; in_sop = sop; in_eop = last; in_data = d; in_tag = tag;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1;
      else if (++n > 60) begin
        n_checks++; n_fail++; done = 1;
        $display("FAIL ready_timeout: beat not accepted within 60 cycles (cycle %0d)", cyc);
      end
      @(posedge clk); #1;
    end
    in_valid = 0; in_sop = 0; in_eop = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (busy && n < 100);
    if (busy) chk("idle_timeout", busy, 0);
    @(posedge clk); #1;
  endtask

  // bub holds a 2-bit idle-cycle count after each byte.
  task automatic send_pkt(input logic [15:0] tag, input int len, input logic [15:0] bub,
                          input logic [7:0] base);
    sop_cyc = cyc;
    for (int i = 0; i < len; i++) begin
      drive_beat(i == 0, i == len - 1, base + 8'(i), tag);
      for (int b = 0; b < int'(bub[2*i +: 2]); b++) idle_cycle();
    end
    wait_idle();
  endtask

  task automatic cfg_write(input logic [5:0] idx, input logic [15:0] mask);
    cfg_we = 1; cfg_stream = idx; cfg_mask = mask;
    idle_cycle();
    cfg_we = 0;
  endtask

  initial begin
    int s, ne;
    in_valid = 0; in_sop = 0; in_eop = 0; in_data = '0; in_tag = '0;
    cfg_we = 0; cfg_stream = '0; cfg_mask = '0; dflt_mask = Dflt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_load_state", load_state, 0);
    chk("reset_eop", eop, 0);
    chk("reset_char_in_vld", char_in_vld, 0);
    chk("reset_stream_id", stream_id, 0);
    chk("reset_enable", enable, 0);
`ifdef DPI_SEQ_ERRCNT_EN
    chk("reset_err_cnt", err_cnt, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1;
    idle_cycle();

    // Single packet "abc" with a new tag.
    send_pkt(16'h1234, 3, 16'h0000, 8'h61);
    s = sop_cyc;
    chk("t1_load_cycle", rec_load, s + 2);
    chk("t1_first_vld", rec_first, s + 4);
    chk("t1_last_vld", rec_last, s + 6);
    chk("t1_nvld", rec_nvld, 3);
    chk("t1_eop_cycle", rec_eop, s + 10);
    chk("t1_stream_id", rec_sid, 0);
    chk("t1_new", rec_new, 1);
    chk("t1_enable", rec_en, Dflt);
    chk("t1_model_sid", m_sid, 0);

    // Repeat tag after a mask update.
    cfg_write(6'd0, 16'hA5A5);
    send_pkt(16'h1234, 2, 16'h0000, 8'h64);
    chk("t2_stream_id", rec_sid, 0);
    chk("t2_new", rec_new, 0);
    chk("t2_enable", rec_en, 16'hA5A5);

    // One-byte packet, then a 5-byte packet with bubbles after bytes 1 and 3.
    send_pkt(16'h2222, 1, 16'h0000, 8'h70);
    s = sop_cyc;
    chk("t3a_first_vld", rec_first, s + 4);
    chk("t3a_eop_cycle", rec_eop, s + 8);
    chk("t3a_stream_id", rec_sid, 1);
    send_pkt(16'h3333, 5, 16'h0084, 8'h80);
    s = sop_cyc;
    chk("t3b_first_vld", rec_first, s + 4);
    chk("t3b_last_vld", rec_last, s + 11);
    chk("t3b_nvld", rec_nvld, 5);
    chk("t3b_eop_cycle", rec_eop, s + 15);
    chk("t3b_stream_id", rec_sid, 2);

    // Stray beat in IDLE, then a SOP arriving mid-packet.
    drive_beat(1'b0, 1'b0, 8'h55, 16'h0000);
    idle_cycle();
    s = cyc;
    drive_beat(1'b1, 1'b0, 8'h10, 16'h4444);
    drive_beat(1'b0, 1'b0, 8'h11, 16'h4444);
    drive_beat(1'b1, 1'b1, 8'h20, 16'h5555);
    chk("t4_abort_eop", rec_eop, s + 9);
    wait_idle();
    chk("t4_next_load", rec_load, s + 12);
    chk("t4_next_eop", rec_eop, s + 18);
    chk("t4_next_stream_id", rec_sid, 4);
    chk("t4_next_new", rec_new, 1);
    chk("t4_model_err", m_err, 2);
`ifdef DPI_SEQ_ERRCNT_EN
    chk("t4_err_cnt", err_cnt, 2);
`endif

    // Reset while streaming.
    drive_beat(1'b1, 1'b0, 8'h30, 16'h6666);
    drive_beat(1'b0, 1'b0, 8'h31, 16'h6666);
    ne = n_eop;
    rst_n = 0;
    idle_cycle();
    idle_cycle();
    rst_n = 1;
    repeat (10) idle_cycle();
    chk("t5_no_eop", n_eop, ne);
    chk("t5_busy", busy, 0);
    chk("t5_stream_id", stream_id, 0);
    chk("t5_enable", enable, 0);
    send_pkt(16'h1234, 1, 16'h0000, 8'h40);
    chk("t5_retag_sid", rec_sid, 0);
    chk("t5_retag_new", rec_new, 1);
    chk("t5_retag_enable", rec_en, Dflt);

    // Fill the table, evict, and wrap the victim pointer.
    for (int i = 1; i < 64; i++) send_pkt(16'h7000 + 16'(i), 1, 16'h0000, 8'(i));
    chk("t6_fill_sid", rec_sid, 63);
    chk("t6_fill_new", rec_new, 1);
    send_pkt(16'h8000, 1, 16'h0000, 8'hC0);
    chk("t6_evict0_sid", rec_sid, 0);
    chk("t6_evict0_new", rec_new, 1);
    send_pkt(16'h8001, 1, 16'h0000, 8'hC1);
    chk("t6_evict1_sid", rec_sid, 1);
    chk("t6_evict1_new", rec_new, 1);
    for (int i = 2; i < 64; i++) send_pkt(16'h8000 + 16'(i), 1, 16'h0000, 8'(i));
    chk("t6_evict63_sid", rec_sid, 63);
    send_pkt(16'h9000, 1, 16'h0000, 8'hD0);
    chk("t6_wrap_sid", rec_sid, 0);
    chk("t6_wrap_new", rec_new, 1);
    send_pkt(16'h8001, 1, 16'h0000, 8'hD1);
    chk("t6_hit_sid", rec_sid, 1);
    chk("t6_hit_new", rec_new, 0);

    repeat (3) idle_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
